// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   hazard_state_t : sequencer state (RUN, MEM_WAIT, FAULT)
//   XZR            : architectural zero register, never a hazard source
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hazard_state_t;

    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current value, holds at all-ones once reached
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use bubble, taken-branch flush, data-memory
// wait freeze with timeout watchdog, and saturating stall/flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; hazards resolved combinationally
// MEM_WAIT | MEM-stage access outstanding; wait counter tracks its age
// FAULT    | access exceeded MEM_TIMEOUT cycles; pipeline frozen until reset
//
// Inputs : clk, rst_n, IF/ID source regs + UsesRm2, ID/EX load info,
//          EX/MEM access/branch info, dmem_ready
// Outputs: PCWrite, IF_ID_Write, ID_EX_Bubble, Flush, Stall_All (Mealy),
//          mem_fault (sticky), stall_cycles, flush_count
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_RegisterRn1,
    input  logic [4:0]       IF_ID_RegisterRm2,
    input  logic             IF_ID_UsesRm2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             EX_MEM_MemAccess,
    input  logic             dmem_ready,
    input  logic             EX_MEM_BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             Flush,
    output logic             Stall_All,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     r_state;
    hazard_state_t     w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              w_mem_stall;
    logic              w_load_use;
    logic              w_stall_inc;

    assign w_mem_stall = EX_MEM_MemAccess & ~dmem_ready;
    assign w_load_use  = ID_EX_MemRead & (ID_EX_RegisterRd != XZR) &
                         ((ID_EX_RegisterRd == IF_ID_RegisterRn1) |
                          (IF_ID_UsesRm2 & (ID_EX_RegisterRd == IF_ID_RegisterRm2)));

    // Mealy control; a branch coincident with mem_stall is not lost because the
    // EX/MEM inputs are held and the flush fires on the release cycle.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        Flush        = 1'b0;
        Stall_All    = 1'b0;
        if (!rst_n) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            Flush        = 1'b1;
        end else if ((r_state == FAULT) || w_mem_stall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            Stall_All   = 1'b1;
        end else if (EX_MEM_BranchTaken) begin
            Flush = 1'b1;
        end else if (w_load_use) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        unique case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!w_mem_stall) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = FAULT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    assign mem_fault   = (r_state == FAULT);
    // Frozen FAULT cycles are not counted as stalls.
    assign w_stall_inc = ~PCWrite & (r_state != FAULT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (Flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

    localparam int MT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    IF_ID_RegisterRn1;
    logic [4:0]    IF_ID_RegisterRm2;
    logic          IF_ID_UsesRm2;
    logic          ID_EX_MemRead;
    logic [4:0]    ID_EX_RegisterRd;
    logic          EX_MEM_MemAccess;
    logic          dmem_ready;
    logic          EX_MEM_BranchTaken;
    logic          PCWrite;
    logic          IF_ID_Write;
    logic          ID_EX_Bubble;
    logic          Flush;
    logic          Stall_All;
    logic          mem_fault;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;

    int tests = 0;
    int fails = 0;

    // reference model: consecutive stalled cycles, fault flag, counters
    int   m_wait  = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    bit   m_fault = 0;
    logic [4:0] e_ctl;

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .IF_ID_RegisterRn1  (IF_ID_RegisterRn1),
        .IF_ID_RegisterRm2  (IF_ID_RegisterRm2),
        .IF_ID_UsesRm2      (IF_ID_UsesRm2),
        .ID_EX_MemRead      (ID_EX_MemRead),
        .ID_EX_RegisterRd   (ID_EX_RegisterRd),
        .EX_MEM_MemAccess   (EX_MEM_MemAccess),
        .dmem_ready         (dmem_ready),
        .EX_MEM_BranchTaken (EX_MEM_BranchTaken),
        .PCWrite            (PCWrite),
        .IF_ID_Write        (IF_ID_Write),
        .ID_EX_Bubble       (ID_EX_Bubble),
        .Flush              (Flush),
        .Stall_All          (Stall_All),
        .mem_fault          (mem_fault),
        .stall_cycles       (stall_cycles),
        .flush_count        (flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // expected {PCWrite, IF_ID_Write, ID_EX_Bubble, Flush, Stall_All}
    function automatic logic [4:0] exp_ctl();
        bit ms, lu;
        ms = EX_MEM_MemAccess && !dmem_ready;
        lu = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd31) &&
             ((ID_EX_RegisterRd == IF_ID_RegisterRn1) ||
              (IF_ID_UsesRm2 && (ID_EX_RegisterRd == IF_ID_RegisterRm2)));
        if (!rst_n)          return 5'b00110;
        else if (m_fault)    return 5'b00001;
        else if (ms)         return 5'b00001;
        else if (EX_MEM_BranchTaken) return 5'b11010;
        else if (lu)         return 5'b00100;
        else                 return 5'b11000;
    endfunction

    // Compare every cycle on the falling edge, then advance the model using
    // the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        e_ctl = exp_ctl();
        chk("PCWrite",      PCWrite,      e_ctl[4]);
        chk("IF_ID_Write",  IF_ID_Write,  e_ctl[3]);
        chk("ID_EX_Bubble", ID_EX_Bubble, e_ctl[2]);
        chk("Flush",        Flush,        e_ctl[1]);
        chk("Stall_All",    Stall_All,    e_ctl[0]);
        if (!rst_n) begin
            m_wait = 0; m_stall = 0; m_flush = 0; m_fault = 0;
        end
        chk("mem_fault",    mem_fault,    m_fault);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_count",  flush_count,  m_flush);
        if (rst_n) begin
            if (!m_fault && !e_ctl[4] && m_stall < CMAX) m_stall++;
            if (e_ctl[1] && m_flush < CMAX) m_flush++;
            if (!m_fault) begin
                if (EX_MEM_MemAccess && !dmem_ready) begin
                    m_wait++;
                    if (m_wait >= MT) m_fault = 1;
                end else begin
                    m_wait = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IF_ID_RegisterRn1  = 5'd0;
        IF_ID_RegisterRm2  = 5'd0;
        IF_ID_UsesRm2      = 1'b0;
        ID_EX_MemRead      = 1'b0;
        ID_EX_RegisterRd   = 5'd0;
        EX_MEM_MemAccess   = 1'b0;
        dmem_ready         = 1'b0;
        EX_MEM_BranchTaken = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 7) == 0) return 5'd31;
        return 5'($urandom_range(0, 3));
    endfunction

    int acc_pct;
    int rdy_pct;

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        #1;
        chk("rst PCWrite",      PCWrite,      0);
        chk("rst IF_ID_Write",  IF_ID_Write,  0);
        chk("rst ID_EX_Bubble", ID_EX_Bubble, 1);
        chk("rst Flush",        Flush,        1);
        chk("rst Stall_All",    Stall_All,    0);
        chk("rst stall_cycles", stall_cycles, 0);
        step();
        rst_n = 1'b1;
        #1 chk("run PCWrite", PCWrite, 1);

        // load X1 in EX, ID reads X1
        step();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd1; IF_ID_RegisterRn1 = 5'd1;
        #1;
        chk("lu PCWrite",      PCWrite,      0);
        chk("lu IF_ID_Write",  IF_ID_Write,  0);
        chk("lu ID_EX_Bubble", ID_EX_Bubble, 1);
        step(); idle();
        #1 chk("lu stall_cycles", stall_cycles, 1);
        // XZR destination never hazards
        step();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd31; IF_ID_RegisterRn1 = 5'd31;
        #1 chk("xzr PCWrite", PCWrite, 1);
        // Rm2 only counts when actually used
        step(); idle();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd2; IF_ID_RegisterRn1 = 5'd5;
        IF_ID_RegisterRm2 = 5'd2; IF_ID_UsesRm2 = 1'b0;
        #1 chk("rm2 unused PCWrite", PCWrite, 1);
        step();
        IF_ID_UsesRm2 = 1'b1;
        #1 chk("rm2 used Bubble", ID_EX_Bubble, 1);
        step(); idle();
        #1 chk("rm2 stall_cycles", stall_cycles, 2);

        // 3-cycle memory wait, then a second one to show the wait count restarts
        do_reset();
        for (int r = 0; r < 2; r++) begin
            EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1 chk("mw Stall_All", Stall_All, 1);
                step();
            end
            dmem_ready = 1'b1;
            #1;
            chk("mw release Stall_All", Stall_All, 0);
            chk("mw release PCWrite",   PCWrite,   1);
            step(); idle();
            #1;
            chk("mw stall_cycles", stall_cycles, 3 * (r + 1));
            chk("mw mem_fault",    mem_fault,    0);
        end

        // branch wins over load-use
        do_reset();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd3; IF_ID_RegisterRn1 = 5'd3;
        EX_MEM_BranchTaken = 1'b1;
        #1;
        chk("br Flush",        Flush,        1);
        chk("br PCWrite",      PCWrite,      1);
        chk("br ID_EX_Bubble", ID_EX_Bubble, 0);
        step(); idle();
        #1 chk("br flush_count", flush_count, 1);
        // branch deferred by a 2-cycle memory wait
        EX_MEM_BranchTaken = 1'b1; EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("brmw Flush held", Flush, 0);
            step();
        end
        dmem_ready = 1'b1;
        #1 chk("brmw Flush release", Flush, 1);
        step(); idle();
        #1;
        chk("brmw flush_count",  flush_count,  2);
        chk("brmw stall_cycles", stall_cycles, 2);

        // timeout after exactly MT stalled cycles
        do_reset();
        EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= MT; i++) begin
            step();
            chk("to mem_fault", mem_fault, (i == MT) ? 1 : 0);
        end
        idle();
        dmem_ready = 1'b1;
        #1;
        chk("fault Stall_All", Stall_All, 1);
        chk("fault PCWrite",   PCWrite,   0);
        repeat (3) step();
        chk("fault stall_cycles", stall_cycles, MT);
        chk("fault held",         mem_fault,    1);
        rst_n = 1'b0;
        #1;
        chk("fault rst mem_fault", mem_fault, 0);
        chk("fault rst Flush",     Flush,     1);
        step();
        rst_n = 1'b1;
        #1;
        chk("post fault PCWrite",      PCWrite,      1);
        chk("post fault stall_cycles", stall_cycles, 0);

        // saturation with a 4-bit counter
        do_reset();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd4; IF_ID_RegisterRn1 = 5'd4;
        repeat (20) step();
        idle();
        #1 chk("sat stall_cycles", stall_cycles, 15);

        // randomized traffic, checked by the model on every cycle
        acc_pct = 30;
        rdy_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 64 == 0) begin
                acc_pct = $urandom_range(0, 100);
                rdy_pct = $urandom_range(0, 100);
            end
            rst_n = ($urandom_range(0, 99) != 0);
            IF_ID_RegisterRn1  = pick_reg();
            IF_ID_RegisterRm2  = pick_reg();
            ID_EX_RegisterRd   = pick_reg();
            IF_ID_UsesRm2      = 1'($urandom_range(0, 1));
            ID_EX_MemRead      = 1'($urandom_range(0, 1));
            EX_MEM_BranchTaken = ($urandom_range(0, 5) == 0);
            EX_MEM_MemAccess   = ($urandom_range(0, 99) < acc_pct);
            dmem_ready         = ($urandom_range(0, 99) < rdy_pct);
        end
        step();
        rst_n = 1'b1;
        idle();
        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
